// File: rtl/eth_ping_pkg.sv
// Shared definitions for the ping RX parser: parser states, header byte
// offsets, counter width and the header byte comparison helper.
package eth_ping_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_TAIL,
    ST_DROP
  } parse_state_t;

  localparam logic [4:0] MAC_DST_OFS = 5'd0;
  localparam logic [4:0] MAC_SRC_OFS = 5'd6;
  localparam logic [4:0] ID_OFS      = 5'd12;
  localparam logic [4:0] SEQ_OFS     = 5'd16;
  localparam logic [4:0] HDR_LEN     = 5'd24;
  localparam logic [4:0] HDR_LAST    = 5'd23;

  localparam int CNT_W = 32;

  // Returns 1 when the byte at header index idx is one of the checked bytes
  // (destination MAC or identifier) and does not carry the expected value.
  function automatic logic header_mismatch(
    input logic [4:0]  idx,
    input logic [7:0]  data,
    input logic [47:0] mac,
    input logic [31:0] id
  );
    logic [47:0] mac_sh;
    logic [31:0] id_sh;
    logic        bad;
    mac_sh = '0;
    id_sh  = '0;
    bad    = 1'b0;
    if (idx < MAC_SRC_OFS) begin
      mac_sh = mac >> (6'd40 - {idx, 3'b000});
      bad    = (mac_sh[7:0] != data);
    end else if (idx >= ID_OFS && idx < SEQ_OFS) begin
      id_sh = id >> (6'd8 * (6'(SEQ_OFS) - 6'd1 - {1'b0, idx}));
      bad   = (id_sh[7:0] != data);
    end
    return bad;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count increment requests, holding once every bit is set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/eth_ping_rx_parser.sv
// RX-side ping frame parser: checks destination MAC and identifier, extracts
// source MAC and 64-bit sequence number, timestamps the first byte and
// reports each accepted frame with a one-cycle pulse plus good/bad totals.
module eth_ping_rx_parser
  import eth_ping_pkg::*;
#(
  parameter logic [47:0] dst_mac    = 48'h7A_65_64_6E_74_6D,
  parameter logic [31:0] identifier = 32'h50696E47
) (
  input  logic             s_axis_clk,
  input  logic             s_axis_rst,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tkeep,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tvalid,
  input  logic [63:0]      current_time,
  input  logic             time_running,
  output logic             ping_valid,
  output logic [63:0]      ping_id,
  output logic [63:0]      ping_time,
  output logic [47:0]      ping_src_mac,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_bad
);

  parse_state_t state;
  logic [4:0]   byte_idx;
  logic         run_flag;
  logic [63:0]  sh_time;
  logic [63:0]  sh_seq;
  logic [47:0]  sh_src;

  logic         is_byte;
  logic         is_last;
  logic [4:0]   cur_idx;
  logic         cur_run;
  logic         byte_bad;
  logic         hit_good;
  logic         hit_bad;
  logic         good_fin;
  logic         bad_fin;
  logic [63:0]  seq_next;

  assign is_byte = s_axis_tvalid && s_axis_tkeep;
  assign is_last = s_axis_tvalid && s_axis_tlast;

  // Decide per beat whether the frame ends here and how it is judged; the
  // first byte is checked from IDLE so a bad byte 0 is never missed.
  always_comb begin
    cur_idx  = (state == ST_IDLE) ? MAC_DST_OFS : byte_idx;
    cur_run  = (state == ST_IDLE) ? time_running : run_flag;
    byte_bad = is_byte && header_mismatch(cur_idx, s_axis_tdata, dst_mac, identifier);
    hit_good = 1'b0;
    hit_bad  = 1'b0;
    seq_next = sh_seq;
    case (state)
      ST_IDLE: hit_bad = is_byte && s_axis_tlast;
      ST_HDR: begin
        if (is_last) begin
          if (is_byte && byte_idx == HDR_LAST) hit_good = 1'b1;
          else                                 hit_bad  = 1'b1;
        end
        if (is_byte && byte_idx >= SEQ_OFS && byte_idx < HDR_LEN)
          seq_next = {sh_seq[55:0], s_axis_tdata};
      end
      ST_TAIL: hit_good = is_last;
      ST_DROP: hit_bad  = is_last;
      default: hit_bad  = 1'b0;
    endcase
    good_fin = hit_good && cur_run;
    bad_fin  = hit_bad && cur_run;
  end

  // Parser FSM with shadow capture and registered result outputs.
  always_ff @(posedge s_axis_clk or posedge s_axis_rst) begin
    if (s_axis_rst) begin
      state        <= ST_IDLE;
      byte_idx     <= '0;
      run_flag     <= 1'b0;
      sh_time      <= '0;
      sh_seq       <= '0;
      sh_src       <= '0;
      ping_valid   <= 1'b0;
      ping_id      <= '0;
      ping_time    <= '0;
      ping_src_mac <= '0;
    end else begin
      ping_valid <= 1'b0;
      if (good_fin) begin
        ping_valid   <= 1'b1;
        ping_id      <= seq_next;
        ping_time    <= sh_time;
        ping_src_mac <= sh_src;
      end
      case (state)
        ST_IDLE: begin
          if (is_byte) begin
            sh_time  <= current_time;
            run_flag <= time_running;
            byte_idx <= 5'd1;
            if (s_axis_tlast)  state <= ST_IDLE;
            else if (byte_bad) state <= ST_DROP;
            else               state <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (is_byte) begin
            byte_idx <= byte_idx + 5'd1;
            sh_seq   <= seq_next;
            if (byte_idx >= MAC_SRC_OFS && byte_idx < ID_OFS)
              sh_src <= {sh_src[39:0], s_axis_tdata};
            if (s_axis_tlast)              state <= ST_IDLE;
            else if (byte_bad)             state <= ST_DROP;
            else if (byte_idx == HDR_LAST) state <= ST_TAIL;
          end else if (is_last) begin
            state <= ST_IDLE;
          end
        end
        ST_TAIL, ST_DROP: begin
          if (is_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_frames_ok (
    .clk   (s_axis_clk),
    .rst   (s_axis_rst),
    .inc   (good_fin),
    .count (frames_ok)
  );

  sat_counter #(.WIDTH(CNT_W)) u_frames_bad (
    .clk   (s_axis_clk),
    .rst   (s_axis_rst),
    .inc   (bad_fin),
    .count (frames_bad)
  );

endmodule

// File: tb/tb_eth_ping_rx_parser.sv
// Bench for eth_ping_rx_parser: queue-based frame model judged at tlast,
// compared against the DUT every cycle, plus literal spot checks.
module tb_eth_ping_rx_parser;

  typedef logic [7:0] byte_q_t[$];

  localparam logic [47:0] DST = 48'h7A656_46E746D;
  localparam logic [31:0] ID  = 32'h50696E47;
  localparam logic [47:0] SRC = 48'h020000000001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tdata = '0;
  logic        tkeep = 1'b0;
  logic        tlast = 1'b0;
  logic        tvalid = 1'b0;
  logic [63:0] current_time = '0;
  logic        time_running = 1'b0;

  logic        ping_valid;
  logic [63:0] ping_id;
  logic [63:0] ping_time;
  logic [47:0] ping_src_mac;
  logic [31:0] frames_ok;
  logic [31:0] frames_bad;

  int checks = 0;
  int errors = 0;
  int preload_req = 0;
  int preload_seen = 0;

  // Model state
  byte_q_t     fq;
  logic        in_frame = 1'b0;
  logic        f_run = 1'b0;
  logic [63:0] f_time = '0;
  logic        m_valid = 1'b0;
  logic [63:0] m_id = '0;
  logic [63:0] m_time = '0;
  logic [47:0] m_src = '0;
  logic [31:0] m_ok = '0;
  logic [31:0] m_bad = '0;

  eth_ping_rx_parser dut (
    .s_axis_clk    (clk),
    .s_axis_rst    (rst),
    .s_axis_tdata  (tdata),
    .s_axis_tkeep  (tkeep),
    .s_axis_tlast  (tlast),
    .s_axis_tvalid (tvalid),
    .current_time  (current_time),
    .time_running  (time_running),
    .ping_valid    (ping_valid),
    .ping_id       (ping_id),
    .ping_time     (ping_time),
    .ping_src_mac  (ping_src_mac),
    .frames_ok     (frames_ok),
    .frames_bad    (frames_bad)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] byte_of(input logic [191:0] v, input int pos, input int nbytes);
    logic [191:0] s;
    s = v >> (8 * (nbytes - 1 - pos));
    return s[7:0];
  endfunction

  // A frame is good when it has a full 24-byte header with the right
  // destination MAC and identifier.
  function automatic logic frame_good(input byte_q_t f);
    if (f.size() < 24) return 1'b0;
    for (int i = 0; i < 6; i++)
      if (f[i] != byte_of({144'd0, DST}, i, 6)) return 1'b0;
    for (int i = 0; i < 4; i++)
      if (f[12 + i] != byte_of({160'd0, ID}, i, 4)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic byte_q_t make_frame(input logic [63:0] seq, input logic [47:0] src, input int len);
    byte_q_t f;
    logic [191:0] hdr;
    hdr = {DST, src, ID, seq};
    for (int i = 0; i < len; i++) begin
      if (i < 24) f.push_back(byte_of(hdr, i, 24));
      else        f.push_back(8'(i));
    end
    return f;
  endfunction

  // Behavioural model: collect the bytes of each frame, judge the whole
  // frame when its tlast beat is seen.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      in_frame = 1'b0;
      m_valid  = 1'b0;
      m_id     = '0;
      m_time   = '0;
      m_src    = '0;
      m_ok     = '0;
      m_bad    = '0;
    end else begin
      if (preload_seen != preload_req) begin
        preload_seen = preload_req;
        m_ok = 32'hFFFFFFFE;
      end
      m_valid = 1'b0;
      if (tvalid) begin
        if (tkeep) begin
          if (!in_frame) begin
            in_frame = 1'b1;
            f_run    = time_running;
            f_time   = current_time;
          end
          fq.push_back(tdata);
        end
        if (tlast && in_frame) begin
          if (f_run) begin
            if (frame_good(fq)) begin
              m_valid = 1'b1;
              m_time  = f_time;
              m_id    = '0;
              for (int i = 16; i < 24; i++) m_id = {m_id[55:0], fq[i]};
              m_src   = '0;
              for (int i = 6; i < 12; i++) m_src = {m_src[39:0], fq[i]};
              if (m_ok != 32'hFFFFFFFF) m_ok = m_ok + 32'd1;
            end else begin
              if (m_bad != 32'hFFFFFFFF) m_bad = m_bad + 32'd1;
            end
          end
          in_frame = 1'b0;
          fq.delete();
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    chk("ping_valid", 64'(ping_valid), 64'(m_valid));
    chk("ping_id", ping_id, m_id);
    chk("ping_time", ping_time, m_time);
    chk("ping_src_mac", 64'(ping_src_mac), 64'(m_src));
    chk("frames_ok", 64'(frames_ok), 64'(m_ok));
    chk("frames_bad", 64'(frames_bad), 64'(m_bad));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_model();
    current_time = current_time + 64'd1;
  endtask

  task automatic beat(input logic [7:0] d, input logic k, input logic l);
    tick();
    tvalid = 1'b1;
    tdata  = d;
    tkeep  = k;
    tlast  = l;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      tvalid = 1'b0;
      tkeep  = 1'b0;
      tlast  = 1'b0;
    end
  endtask

  task automatic send_frame(input byte_q_t f, input int gap_pct, input logic keepless_end,
                            input int run_on_at, input int rst_at);
    for (int i = 0; i < f.size(); i++) begin
      if (i > 0 && $urandom_range(0, 99) < gap_pct)
        beat(8'($urandom_range(0, 255)), 1'b0, 1'b0);
      beat(f[i], 1'b1, (i == f.size() - 1) && !keepless_end);
      if (i == run_on_at) time_running = 1'b1;
      if (i == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_ping_valid", 64'(ping_valid), 64'd0);
        chk("rst_ping_id", ping_id, 64'd0);
        chk("rst_frames_ok", 64'(frames_ok), 64'd0);
        chk("rst_frames_bad", 64'(frames_bad), 64'd0);
        #3 rst = 1'b0;
      end
    end
    if (keepless_end) beat(8'($urandom_range(0, 255)), 1'b0, 1'b1);
  endtask

  task automatic applyStimulus();
    byte_q_t f;
    int kind;
    int len;
    int pos;

    // Reset state
    idle(2);
    chk("reset_frames_ok", 64'(frames_ok), 64'd0);
    chk("reset_ping_valid", 64'(ping_valid), 64'd0);
    rst = 1'b0;
    idle(2);

    // Valid 60-byte frame stamped at time 1000
    time_running = 1'b1;
    current_time = 64'd999;
    send_frame(make_frame(64'h1234, SRC, 60), 0, 1'b0, -1, -1);
    idle(1);
    chk("v_ping_valid", 64'(ping_valid), 64'd1);
    chk("v_ping_id", ping_id, 64'h1234);
    chk("v_ping_time", ping_time, 64'd1000);
    chk("v_src", 64'(ping_src_mac), 64'h020000000001);
    chk("v_frames_ok", 64'(frames_ok), 64'd1);
    idle(2);

    // Wrong destination, then wrong identifier
    f = make_frame(64'd7, SRC, 60);
    f[5] = 8'h00;
    send_frame(f, 0, 1'b0, -1, -1);
    idle(2);
    f = make_frame(64'd8, SRC, 60);
    f[15] = 8'h48;
    send_frame(f, 0, 1'b0, -1, -1);
    idle(2);
    chk("mm_frames_bad", 64'(frames_bad), 64'd2);
    chk("mm_frames_ok", 64'(frames_ok), 64'd1);

    // Truncated 20-byte frame, then minimal 24-byte frame
    send_frame(make_frame(64'd9, SRC, 20), 0, 1'b0, -1, -1);
    idle(2);
    chk("trunc_frames_bad", 64'(frames_bad), 64'd3);
    send_frame(make_frame(64'hABCD, SRC, 24), 0, 1'b0, -1, -1);
    idle(1);
    chk("h24_ping_valid", 64'(ping_valid), 64'd1);
    chk("h24_ping_id", ping_id, 64'hABCD);
    chk("h24_frames_ok", 64'(frames_ok), 64'd2);

    // Back-to-back with keepless beats mid-header
    send_frame(make_frame(64'd1, SRC, 30), 30, 1'b0, -1, -1);
    send_frame(make_frame(64'd2, 48'h0A0B0C0D0E0F, 28), 30, 1'b0, -1, -1);
    idle(1);
    chk("b2b_ping_id", ping_id, 64'd2);
    chk("b2b_frames_ok", 64'(frames_ok), 64'd4);
    idle(1);

    // Timer stopped at first byte, raised mid-frame
    time_running = 1'b0;
    idle(1);
    send_frame(make_frame(64'd77, SRC, 40), 0, 1'b0, 5, -1);
    idle(2);
    chk("stop_frames_ok", 64'(frames_ok), 64'd4);
    chk("stop_frames_bad", 64'(frames_bad), 64'd3);

    // Randomized mix of good, mismatched, truncated and keepless-ended frames
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      time_running = ($urandom_range(0, 3) != 0);
      if (kind == 5) len = $urandom_range(1, 23);
      else           len = $urandom_range(24, 64);
      f = make_frame({$urandom, $urandom}, {16'h0200, $urandom}, len);
      if (kind == 3) begin
        pos = $urandom_range(0, 5);
        f[pos] = f[pos] ^ 8'h01;
      end else if (kind == 4) begin
        pos = $urandom_range(12, 15);
        f[pos] = f[pos] ^ 8'h80;
      end
      send_frame(f, $urandom_range(0, 25), ($urandom_range(0, 3) == 0), -1, -1);
      idle($urandom_range(0, 2));
    end
    idle(2);

    // Reset at byte 10, leftover bytes form a bad frame, then a good one
    time_running = 1'b1;
    send_frame(make_frame(64'd55, SRC, 60), 0, 1'b0, -1, 10);
    idle(2);
    chk("prst_frames_bad", 64'(frames_bad), 64'd1);
    chk("prst_frames_ok", 64'(frames_ok), 64'd0);
    send_frame(make_frame(64'd56, SRC, 60), 0, 1'b0, -1, -1);
    idle(1);
    chk("prst_ping_id", ping_id, 64'd56);
    chk("prst_ok_after", 64'(frames_ok), 64'd1);

    // Saturation from a preloaded count
    idle(1);
    #2;
    force dut.u_frames_ok.count = 32'hFFFFFFFE;
    preload_req = preload_req + 1;
    idle(1);
    #2;
    release dut.u_frames_ok.count;
    for (int n = 0; n < 3; n++) send_frame(make_frame(64'(100 + n), SRC, 30), 10, 1'b0, -1, -1);
    idle(2);
    chk("sat_frames_ok", 64'(frames_ok), 64'hFFFFFFFF);
  endtask

  initial begin
    applyStimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
